// File: rtl/icache_miss_handler_pkg.sv
// Shared ICache types, geometry constants and tag-entry helper used by the miss handler.
package icache_miss_handler_pkg;

    localparam int ICACHE_LINE_WORDS = 8;
    localparam int ICACHE_INDEX_BITS = 6;
    localparam int ICACHE_OFS_BITS   = $clog2(ICACHE_LINE_WORDS) + 2;
    localparam int ICACHE_TAG_BITS   = 32 - ICACHE_OFS_BITS - ICACHE_INDEX_BITS;

    typedef logic [31:0] paddr_t;
    typedef logic [31:0] reg_data_t;

    typedef struct packed {
        logic                       valid;
        logic [ICACHE_TAG_BITS-1:0] tag;
    } icache_tag_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        MEM_REQ,
        BEAT,
        DONE
    } icache_mhu_state_t;

    // A composed entry is always valid; invalid entries are written as all-zero.
    function automatic icache_tag_entry_t compose_icache_tag_entry(input paddr_t paddr);
        icache_tag_entry_t e;
        e.valid = 1'b1;
        e.tag   = ICACHE_TAG_BITS'(paddr >> (ICACHE_OFS_BITS + ICACHE_INDEX_BITS));
        return e;
    endfunction

endpackage

// File: rtl/icache_miss_handler.sv
// ICache miss handler: one outstanding miss, line refill for cached misses,
// single-word read for uncached misses, flush kills the return but not the bus burst.
module icache_miss_handler
    import icache_miss_handler_pkg::*;
#(
    parameter int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int INDEX_BITS = ICACHE_INDEX_BITS
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_flush,
    input  logic                                   i_miss_req,
    input  paddr_t                                 i_miss_paddr,
    input  logic                                   i_miss_cached,
    output logic                                   o_miss_avail,
    output logic                                   o_miss_returned,
    output reg_data_t                              o_miss_data,
    output logic                                   o_mem_req,
    output paddr_t                                 o_mem_addr,
    output logic [$clog2(LINE_WORDS):0]            o_mem_len,
    input  logic                                   i_mem_gnt,
    input  logic                                   i_mem_valid,
    input  reg_data_t                              i_mem_data,
    output logic                                   o_refill_data_we,
    output logic [INDEX_BITS+$clog2(LINE_WORDS)-1:0] o_refill_data_idx,
    output reg_data_t                              o_refill_data,
    output logic                                   o_refill_tag_we,
    output logic [INDEX_BITS-1:0]                  o_refill_tag_idx,
    output icache_tag_entry_t                      o_refill_tag,
    input  logic [31:0]                            i_log_fd
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int LEN_W  = BEAT_W + 1;
    localparam int OFS    = BEAT_W + 2;
    localparam paddr_t LINE_MASK = ~32'(LINE_WORDS * 4 - 1);
    localparam paddr_t WORD_MASK = ~32'd3;

    icache_mhu_state_t state;
    paddr_t            paddr_q;
    logic              cached_q;
    logic              kill_q;
    logic [BEAT_W-1:0] beat_q;
    reg_data_t         capture_q;
    reg_data_t         miss_data_q;

    logic                  accept;
    logic                  last_beat;
    logic                  word_hit;
    logic [LEN_W-1:0]      len;
    logic [INDEX_BITS-1:0] index;

    assign o_miss_avail = (state == IDLE) && !i_flush;
    assign accept       = i_miss_req && o_miss_avail;
    assign index        = paddr_q[OFS+INDEX_BITS-1:OFS];
    assign len          = cached_q ? LEN_W'(LINE_WORDS) : LEN_W'(1);
    assign last_beat    = ({1'b0, beat_q} == len - LEN_W'(1));
    assign word_hit     = !cached_q || (beat_q == paddr_q[OFS-1:2]);
    assign o_miss_data  = miss_data_q;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            paddr_q     <= '0;
            cached_q    <= 1'b0;
            kill_q      <= 1'b0;
            beat_q      <= '0;
            capture_q   <= '0;
            miss_data_q <= '0;
        end else begin
            if (state != IDLE && i_flush)
                kill_q <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        paddr_q  <= i_miss_paddr;
                        cached_q <= i_miss_cached;
                        kill_q   <= 1'b0;
                        beat_q   <= '0;
                        state    <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    if (i_mem_gnt)
                        state <= BEAT;
                end
                BEAT: begin
                    if (i_mem_valid) begin
                        if (word_hit)
                            capture_q <= i_mem_data;
                        beat_q <= beat_q + BEAT_W'(1);
                        if (last_beat) begin
                            state <= DONE;
                            // Only a surviving miss updates the returned word.
                            if (!kill_q && !i_flush)
                                miss_data_q <= word_hit ? i_mem_data : capture_q;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        o_mem_req         = (state == MEM_REQ);
        o_mem_addr        = '0;
        o_mem_len         = '0;
        o_refill_data_we  = (state == BEAT) && cached_q && i_mem_valid;
        o_refill_data_idx = '0;
        o_refill_data     = '0;
        o_miss_returned   = (state == DONE) && !kill_q && !i_flush;
        o_refill_tag_we   = 1'b0;
        o_refill_tag_idx  = '0;
        o_refill_tag      = '0;

        if (state != IDLE) begin
            o_mem_addr = paddr_q & (cached_q ? LINE_MASK : WORD_MASK);
            o_mem_len  = len;
        end
        if (o_refill_data_we) begin
            o_refill_data_idx = {index, beat_q};
            o_refill_data     = i_mem_data;
        end
        // Keep the set invalid while the line is partially written.
        if (cached_q && state == MEM_REQ) begin
            o_refill_tag_we  = 1'b1;
            o_refill_tag_idx = index;
        end else if (cached_q && o_miss_returned) begin
            o_refill_tag_we  = 1'b1;
            o_refill_tag_idx = index;
            o_refill_tag     = compose_icache_tag_entry(paddr_q);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && i_log_fd != 32'd0) begin
            if (accept)
                $display("[icache_mhu] accept paddr=%h cached=%0d", i_miss_paddr, i_miss_cached);
            if (o_mem_req && i_mem_gnt)
                $display("[icache_mhu] grant addr=%h len=%0d", o_mem_addr, o_mem_len);
            if (o_miss_returned)
                $display("[icache_mhu] return data=%h", miss_data_q);
            if (i_flush && state != IDLE && !kill_q)
                $display("[icache_mhu] kill paddr=%h", paddr_q);
        end
    end

endmodule

// File: tb/tb_icache_miss_handler.sv
// Directed self-checking bench for icache_miss_handler: cached/uncached fills, bus stalls,
// flush, ignored requests and mid-burst reset, each against hand-computed values.
module tb_icache_miss_handler;
    import icache_miss_handler_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              miss_req;
    paddr_t            miss_paddr;
    logic              miss_cached;
    logic              miss_avail;
    logic              miss_returned;
    reg_data_t         miss_data;
    logic              mem_req;
    paddr_t            mem_addr;
    logic [3:0]        mem_len;
    logic              mem_gnt;
    logic              mem_valid;
    reg_data_t         mem_data;
    logic              refill_data_we;
    logic [8:0]        refill_data_idx;
    reg_data_t         refill_data;
    logic              refill_tag_we;
    logic [5:0]        refill_tag_idx;
    icache_tag_entry_t refill_tag;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    icache_miss_handler dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_flush           (flush),
        .i_miss_req        (miss_req),
        .i_miss_paddr      (miss_paddr),
        .i_miss_cached     (miss_cached),
        .o_miss_avail      (miss_avail),
        .o_miss_returned   (miss_returned),
        .o_miss_data       (miss_data),
        .o_mem_req         (mem_req),
        .o_mem_addr        (mem_addr),
        .o_mem_len         (mem_len),
        .i_mem_gnt         (mem_gnt),
        .i_mem_valid       (mem_valid),
        .i_mem_data        (mem_data),
        .o_refill_data_we  (refill_data_we),
        .o_refill_data_idx (refill_data_idx),
        .o_refill_data     (refill_data),
        .o_refill_tag_we   (refill_tag_we),
        .o_refill_tag_idx  (refill_tag_idx),
        .o_refill_tag      (refill_tag),
        .i_log_fd          (32'd0)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; miss_req = 1'b0; mem_gnt = 1'b0; mem_valid = 1'b0; mem_data = 32'hBAD0_BAD0;
    endtask

    initial begin
        rst_n = 1'b0; idle_inputs(); miss_paddr = '0; miss_cached = 1'b0;
        next_cycle(); next_cycle();
        #1;
        check("rst_avail", miss_avail, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_returned", miss_returned, 0);
        check("rst_tag_we", refill_tag_we, 0);
        check("rst_data", miss_data, 0);
        rst_n = 1'b1;
        next_cycle();

        // Test 1: cached zero-wait fill, paddr 0x8000_1014 (index 0, word 5).
        miss_req = 1'b1; miss_paddr = 32'h8000_1014; miss_cached = 1'b1;
        #1; check("t1_avail", miss_avail, 1);
        next_cycle();
        miss_req = 1'b0; mem_gnt = 1'b1;
        #1;
        check("t1_mem_req", mem_req, 1);
        check("t1_mem_addr", mem_addr, 32'h8000_1000);
        check("t1_mem_len", mem_len, 8);
        check("t1_busy", miss_avail, 0);
        check("t1_inv_tag_we", refill_tag_we, 1);
        check("t1_inv_tag", refill_tag, 22'h0);
        check("t1_inv_tag_idx", refill_tag_idx, 0);
        next_cycle();
        mem_gnt = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mem_valid = 1'b1; mem_data = 32'h100 + k;
            #1;
            check("t1_we", refill_data_we, 1);
            check("t1_idx", refill_data_idx, k);
            check("t1_wdata", refill_data, 32'h100 + k);
            check("t1_no_ret", miss_returned, 0);
            next_cycle();
        end
        mem_valid = 1'b0;
        #1;
        check("t1_returned", miss_returned, 1);
        check("t1_data", miss_data, 32'h105);
        check("t1_tag_we", refill_tag_we, 1);
        check("t1_tag", refill_tag, 22'h30_0002);
        next_cycle();
        #1;
        check("t1_avail_after", miss_avail, 1);
        check("t1_ret_pulse", miss_returned, 0);

        // Test 2: uncached read, paddr 0x1000_0006.
        miss_req = 1'b1; miss_paddr = 32'h1000_0006; miss_cached = 1'b0;
        next_cycle();
        miss_req = 1'b0; mem_gnt = 1'b1;
        #1;
        check("t2_mem_addr", mem_addr, 32'h1000_0004);
        check("t2_mem_len", mem_len, 1);
        check("t2_tag_we", refill_tag_we, 0);
        next_cycle();
        mem_gnt = 1'b0; mem_valid = 1'b1; mem_data = 32'hDEAD_BEEF;
        #1; check("t2_data_we", refill_data_we, 0);
        next_cycle();
        mem_valid = 1'b0;
        #1;
        check("t2_returned", miss_returned, 1);
        check("t2_data", miss_data, 32'hDEAD_BEEF);
        check("t2_tag_we_done", refill_tag_we, 0);
        next_cycle();

        // Test 3: paddr 0x8000_2468 (index 0x23, word 2), grant after 5 cycles, valid toggling.
        miss_req = 1'b1; miss_paddr = 32'h8000_2468; miss_cached = 1'b1;
        next_cycle();
        miss_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_req_held", mem_req, 1);
            check("t3_inv_tag_idx", refill_tag_idx, 6'h23);
            next_cycle();
        end
        mem_gnt = 1'b1;
        next_cycle();
        mem_gnt = 1'b0;
        for (int i = 0; i < 15; i++) begin
            mem_valid = (i % 2 == 0);
            mem_data  = mem_valid ? 32'h200 + i / 2 : 32'hBAD;
            #1;
            check("t3_we", refill_data_we, mem_valid);
            if (mem_valid) check("t3_idx", refill_data_idx, 9'h118 + i / 2);
            next_cycle();
        end
        mem_valid = 1'b0;
        #1;
        check("t3_returned", miss_returned, 1);
        check("t3_data", miss_data, 32'h202);
        check("t3_tag", refill_tag, 22'h30_0004);
        next_cycle();

        // Test 4: flush during beat 3 of a cached fill.
        miss_req = 1'b1; miss_paddr = 32'h8000_1014; miss_cached = 1'b1;
        next_cycle();
        miss_req = 1'b0; mem_gnt = 1'b1;
        next_cycle();
        mem_gnt = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mem_valid = 1'b1; mem_data = 32'h400 + k; flush = (k == 3);
            #1;
            check("t4_we", refill_data_we, 1);
            check("t4_idx", refill_data_idx, k);
            if (k == 3) check("t4_avail_flush", miss_avail, 0);
            next_cycle();
        end
        mem_valid = 1'b0; flush = 1'b0;
        #1;
        check("t4_no_return", miss_returned, 0);
        check("t4_no_tag_we", refill_tag_we, 0);
        check("t4_data_held", miss_data, 32'h202);
        next_cycle();
        #1; check("t4_avail_after", miss_avail, 1);

        // Test 5: request while busy and request with flush are both ignored.
        miss_req = 1'b1; miss_paddr = 32'h8000_0040; miss_cached = 1'b1;
        next_cycle();
        miss_paddr = 32'h9000_0000;
        #1;
        check("t5_busy_avail", miss_avail, 0);
        check("t5_addr", mem_addr, 32'h8000_0040);
        next_cycle();
        miss_req = 1'b0; mem_gnt = 1'b1;
        next_cycle();
        mem_gnt = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mem_valid = 1'b1; mem_data = 32'h300 + k;
            next_cycle();
        end
        mem_valid = 1'b0;
        #1;
        check("t5_returned", miss_returned, 1);
        check("t5_data", miss_data, 32'h300);
        check("t5_tag", refill_tag, 22'h30_0000);
        check("t5_tag_idx", refill_tag_idx, 2);
        next_cycle();
        miss_req = 1'b1; flush = 1'b1; miss_paddr = 32'h9000_0000;
        #1; check("t5_flush_avail", miss_avail, 0);
        next_cycle();
        miss_req = 1'b0; flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5_no_bus", mem_req, 0);
            check("t5_idle", miss_avail, 1);
            next_cycle();
        end

        // Test 6: reset during BEAT, then a fresh uncached miss.
        miss_req = 1'b1; miss_paddr = 32'h8000_1014; miss_cached = 1'b1;
        next_cycle();
        miss_req = 1'b0; mem_gnt = 1'b1;
        next_cycle();
        mem_gnt = 1'b0; mem_valid = 1'b1; mem_data = 32'h500;
        next_cycle();
        mem_data = 32'h501;
        next_cycle();
        rst_n = 1'b0; mem_data = 32'h502;
        next_cycle();
        rst_n = 1'b1; mem_valid = 1'b0;
        #1;
        check("t6_avail", miss_avail, 1);
        check("t6_mem_req", mem_req, 0);
        check("t6_mem_addr", mem_addr, 0);
        check("t6_mem_len", mem_len, 0);
        check("t6_data_we", refill_data_we, 0);
        check("t6_tag_we", refill_tag_we, 0);
        check("t6_returned", miss_returned, 0);
        check("t6_data", miss_data, 0);
        miss_req = 1'b1; miss_paddr = 32'h0000_0100; miss_cached = 1'b0;
        next_cycle();
        miss_req = 1'b0; mem_gnt = 1'b1;
        #1; check("t6_new_addr", mem_addr, 32'h0000_0100);
        next_cycle();
        mem_gnt = 1'b0; mem_valid = 1'b1; mem_data = 32'hCAFE_F00D;
        next_cycle();
        mem_valid = 1'b0;
        #1;
        check("t6_new_returned", miss_returned, 1);
        check("t6_new_data", miss_data, 32'hCAFE_F00D);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
